// File: rtl/alu.sv
// 32-bit MIPS-style ALU with registered outputs and a one-cycle result-valid strobe (We).
// Ops 0-6 finish in one clock. Op 7 is an unsigned remainder computed by restoring shift-subtract.
module alu #(
  parameter int         WIDTH  = 32,
  parameter logic [2:0] OP_MOD = 3'd7
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             Z,
  output logic             V,
  output logic             C,
  output logic [WIDTH-1:0] Result,
  output logic             We
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, v_q, v_d, c_q, c_d, we_q, we_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic [5:0]       cnt_q, cnt_d;

  logic [WIDTH:0]   sum, diff, trial;
  logic [WIDTH-1:0] op_res;
  logic             op_v, op_c;

  assign sum   = {1'b0, A} + {1'b0, B};
  assign diff  = {1'b0, A} - {1'b0, B};
  // Next partial remainder candidate: shift in the next dividend bit from the top.
  assign trial = {rem_q, dvd_q[WIDTH-1]};

  always_comb begin
    op_res = '0;
    op_v   = 1'b0;
    op_c   = 1'b0;
    case (ALUOp)
      3'd0: begin
        op_res = sum[WIDTH-1:0];
        op_c   = sum[WIDTH];
        op_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'd1: begin
        op_res = diff[WIDTH-1:0];
        op_c   = ~diff[WIDTH];
        op_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      3'd2:    op_res = A & B;
      3'd3:    op_res = A | B;
      3'd4:    op_res = A ^ B;
      3'd5:    op_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      3'd6:    op_res = ~(A | B);
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    z_d      = z_q;
    v_d      = v_q;
    c_d      = c_q;
    we_d     = 1'b0;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (ALUOp == OP_MOD) begin
          dvd_d   = A;
          dvs_d   = B;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          result_d = op_res;
          z_d      = (op_res == '0);
          v_d      = op_v;
          c_d      = op_c;
          we_d     = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == 6'(WIDTH)) begin
          // A zero divisor never fails the compare, so the remainder naturally ends up equal to A.
          result_d = rem_q;
          z_d      = (rem_q == '0);
          v_d      = (dvs_q == '0);
          c_d      = 1'b0;
          we_d     = 1'b1;
          state_d  = DONE;
        end else begin
          dvd_d = dvd_q << 1;
          if (trial >= {1'b0, dvs_q}) begin
            rem_d = trial[WIDTH-1:0] - dvs_q;
          end else begin
            rem_d = trial[WIDTH-1:0];
          end
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      z_q      <= 1'b1;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      we_q     <= 1'b0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      v_q      <= v_d;
      c_q      <= c_d;
      we_q     <= we_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Result = result_q;
  assign Z      = z_q;
  assign V      = v_q;
  assign C      = c_q;
  assign We     = we_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vectors with literal expectations, plus a per-cycle reference model
// that predicts when We fires and what Result/Z/V/C must be (or must hold) on every cycle.
module tb_alu;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  ALUOp = 3'd0;
  logic        Z, V, C, We;
  logic [31:0] Result;

  int checks = 0;
  int failures = 0;

  alu dut (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .ALUOp(ALUOp),
    .Z(Z), .V(V), .C(C), .Result(Result), .We(We)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] res;
    logic        z, v, c;
  } exp_t;

  exp_t sched[int];
  exp_t last;
  int   cyc = 0;
  int   block = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t model_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    exp_t   e;
    longint s;
    longint u;
    e.v = 1'b0;
    e.c = 1'b0;
    case (op)
      3'd0: begin
        u     = longint'(a) + longint'(b);
        e.res = u[31:0];
        e.c   = (u > 64'sd4294967295);
        s     = longint'($signed(a)) + longint'($signed(b));
        e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = longint'($signed(a)) - longint'($signed(b));
        e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: e.res = ~(a | b);
      default: begin
        e.res = (b == 0) ? a : a % b;
        e.v   = (b == 0);
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Reference model: an op sampled at edge n shows at edge n (ops 0-6) or edge n+33 (MOD);
  // after a MOD the next 34 edges do not sample inputs.
  always @(posedge Clk) begin
    cyc++;
    if (!Reset) begin
      sched.delete();
      block = 0;
      last  = '{res: 32'd0, z: 1'b1, v: 1'b0, c: 1'b0};
    end else if (block > 0) begin
      block--;
    end else if (ALUOp == 3'd7) begin
      sched[cyc + 33] = model_op(ALUOp, A, B);
      block = 34;
    end else begin
      sched[cyc] = model_op(ALUOp, A, B);
    end
  end

  always @(negedge Clk) begin
    if (Reset) begin
      if (sched.exists(cyc)) begin
        exp_t e;
        e = sched[cyc];
        chk($sformatf("c%0d_we", cyc), 32'(We), 32'd1);
        chk($sformatf("c%0d_result", cyc), Result, e.res);
        chk($sformatf("c%0d_zvc", cyc), {29'd0, Z, V, C}, {29'd0, e.z, e.v, e.c});
        last = e;
        sched.delete(cyc);
      end else begin
        chk($sformatf("c%0d_we_low", cyc), 32'(We), 32'd0);
        chk($sformatf("c%0d_hold", cyc), Result, last.res);
        chk($sformatf("c%0d_hold_zvc", cyc), {29'd0, Z, V, C}, {29'd0, last.z, last.v, last.c});
      end
    end
  end

  // Called at a negedge; drives the op and waits (bounded) for the We strobe.
  task automatic run_lit(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] r, logic z, logic v, logic c);
    int n = 0;
    ALUOp = op;
    A = a;
    B = b;
    do begin
      @(negedge Clk);
      n++;
    end while (We !== 1'b1 && n < 40);
    if (We !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: We not seen within %0d cycles", name, n);
    end else begin
      chk({name, "_result"}, Result, r);
      chk({name, "_zvc"}, {29'd0, Z, V, C}, {29'd0, z, v, c});
      $display("%s: op=%0d A=%h B=%h -> Result=%h Z=%b V=%b C=%b after %0d cycles",
               name, op, a, b, Result, Z, V, C, n);
    end
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk("reset_result", Result, 32'd0);
    chk("reset_flags", {28'd0, Z, V, C, We}, {28'd0, 4'b1000});
    Reset = 1'b1;

    run_lit("mod_16_5",   3'd7, 32'd16,        32'd5,  32'd1,        1'b0, 1'b0, 1'b0);
    run_lit("mod_42_11",  3'd7, 32'd42,        32'd11, 32'd9,        1'b0, 1'b0, 1'b0);
    run_lit("mod_20_5",   3'd7, 32'd20,        32'd5,  32'd0,        1'b1, 1'b0, 1'b0);
    run_lit("mod_123_0",  3'd7, 32'd123,       32'd0,  32'd123,      1'b0, 1'b1, 1'b0);
    run_lit("mod_max_7",  3'd7, 32'hFFFFFFFF,  32'd7,  32'd3,        1'b0, 1'b0, 1'b0);
    run_lit("add_ovf",    3'd0, 32'h7FFFFFFF,  32'd1,  32'h80000000, 1'b0, 1'b1, 1'b0);
    run_lit("add_carry",  3'd0, 32'hFFFFFFFF,  32'd1,  32'd0,        1'b1, 1'b0, 1'b1);
    run_lit("sub_borrow", 3'd1, 32'd5,         32'd7,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_lit("sub_ok",     3'd1, 32'd7,         32'd5,  32'd2,        1'b0, 1'b0, 1'b1);
    run_lit("sub_ovf",    3'd1, 32'h80000000,  32'd1,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    run_lit("and",        3'd2, 32'hF0F0F0F0,  32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
    run_lit("or",         3'd3, 32'hF0F0F0F0,  32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    run_lit("xor",        3'd4, 32'hF0F0F0F0,  32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    run_lit("slt_neg",    3'd5, 32'hFFFFFFFF,  32'd1,  32'd1,        1'b0, 1'b0, 1'b0);
    run_lit("slt_pos",    3'd5, 32'd1,         32'hFFFFFFFF, 32'd0,  1'b1, 1'b0, 1'b0);
    run_lit("nor",        3'd6, 32'd0,         32'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

    // Abort a MOD part-way through with an asynchronous reset.
    ALUOp = 3'd7;
    A = 32'd1000;
    B = 32'd7;
    repeat (10) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("abort_result", Result, 32'd0);
    chk("abort_flags", {28'd0, Z, V, C, We}, {28'd0, 4'b1000});
    ALUOp = 3'd0;
    A = 32'd3;
    B = 32'd4;
    @(negedge Clk);
    Reset = 1'b1;
    run_lit("post_abort_add", 3'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);
    ALUOp = 3'd4;
    A = 32'h12345678;
    B = 32'h0000FFFF;
    repeat (40) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
